hazard_ctrl_unit: RTL
=====================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width; register 0 is the hardwired zero register.
REQ-002 SHALL have parameter MC_LAT, default 4, multi-cycle unit latency in cycles; legal range 2..15.
REQ-003 SHALL have port in_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port in_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_id_valid  input  1  ID stage holds a live (non-squashed) instruction.
REQ-006 SHALL have port in_id_rs1  input  REG_AW  ID source 1.
REQ-007 SHALL have port in_id_rs2  input  REG_AW  ID source 2.
REQ-008 SHALL have port in_id_mc_op  input  1  ID instruction targets the multi-cycle unit.
REQ-009 SHALL have port in_idex_rs1  input  REG_AW  EX source 1.
REQ-010 SHALL have port in_idex_rs2  input  REG_AW  EX source 2.
REQ-011 SHALL have port in_idex_rd  input  REG_AW  EX destination.
REQ-012 SHALL have port in_idex_memread  input  1  EX instruction is a load.
REQ-013 SHALL have port in_idex_mc_start  input  1  EX instruction issues to the multi-cycle unit this cycle.
REQ-014 SHALL have port in_exmem_regwrite  input  1  MEM instruction writes a register.
REQ-015 SHALL have port in_exmem_rd  input  REG_AW  MEM destination.
REQ-016 SHALL have port in_memwb_regwrite  input  1  WB instruction writes a register.
REQ-017 SHALL have port in_memwb_rd  input  REG_AW  WB destination.
REQ-018 SHALL have port in_perf_clr  input  1  synchronous clear of the stall counter.
REQ-019 SHALL have ports out_forwarda_sel / out_forwardb_sel  output  2 each  operand mux select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-020 SHALL have port out_stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-021 SHALL have port out_mc_busy  output  1  multi-cycle unit occupied.
REQ-022 SHALL have port out_mc_wb_valid  output  1  multi-cycle result writes back this cycle.
REQ-023 SHALL have port out_mc_rd  output  REG_AW  destination of the pending multi-cycle op.
REQ-024 SHALL have port out_mc_start_ack  output  1  in_idex_mc_start accepted this cycle.
REQ-025 SHALL have port out_stall_cycles  output  16  saturating count of stalled cycles.

Function
REQ-026 Forward select per operand SHALL be combinational: 10 if exmem_regwrite, exmem_rd!=0 and exmem_rd==idex_rsX; else 01 if memwb_regwrite, memwb_rd!=0 and memwb_rd==idex_rsX; else 00 (EX/MEM wins when both match).
REQ-027 Load-use hazard SHALL be: id_valid, idex_memread, idex_rd!=0, idex_rd equal to id_rs1 or id_rs2; combinational, stalls exactly one cycle per occurrence.
REQ-028 Multi-cycle state SHALL be IDLE (busy=0) and RUN (busy=1, down-counter cnt of width 4, latched rd).
REQ-029 out_mc_start_ack SHALL equal in_idex_mc_start AND (IDLE OR (RUN AND cnt==0)); ignored starts leave state unchanged.
REQ-030 On an acknowledged start, next state SHALL be RUN with cnt=MC_LAT-1 and rd=in_idex_rd.
REQ-031 In RUN with cnt!=0, cnt SHALL decrement by 1 per cycle.
REQ-032 In RUN with cnt==0, out_mc_wb_valid SHALL be 1 that cycle; next state IDLE unless a start is acknowledged the same cycle (back-to-back reload).
REQ-033 out_mc_wb_valid SHALL therefore assert exactly MC_LAT cycles after the start cycle, for one cycle.
REQ-034 RAW-on-pending hazard SHALL be: id_valid, RUN, cnt!=0, out_mc_rd!=0, out_mc_rd equal to id_rs1 or id_rs2; no stall in the wb_valid cycle.
REQ-035 Structural hazard SHALL be: id_valid, id_mc_op, and either (RUN, cnt!=0) or an acknowledged start this cycle.
REQ-036 out_stall SHALL be the OR of load-use, RAW-on-pending and structural hazards; id_valid=0 forces out_stall=0.
REQ-037 out_stall_cycles SHALL increment when out_stall=1, hold at 16'hFFFF, clear on in_perf_clr (clear wins over increment).

Reset
REQ-038 While in_rst_n=0 state SHALL be IDLE, cnt=0, out_mc_rd=0, out_stall_cycles=0; out_mc_busy, out_mc_wb_valid, out_mc_start_ack=0 and, with inputs low, out_stall=0 and forward selects=00.
REQ-039 Reset asserted mid-RUN SHALL abort the op immediately with no out_mc_wb_valid pulse after release.

Verification
REQ-040 exmem rd=5 regwrite=1, memwb rd=5 regwrite=1, idex_rs1=5, idex_rs2=0 -> forwarda=10, forwardb=00.
REQ-041 idex load rd=7, id_rs2=7, id_valid=1 -> out_stall=1 one cycle, stall_cycles +1; rd=0 -> no stall.
REQ-042 MC_LAT=4, start rd=9 at cycle 0, id_rs1=9 held -> stall cycles 1-3, wb_valid and no stall at cycle 4, busy=0 at cycle 5.
REQ-043 Second start in wb_valid cycle -> ack=1, cnt reloads to 3, busy stays 1, second wb_valid at cycle 8; start at cycle 2 -> ack=0.
REQ-044 in_rst_n low at cycle 2 of a run -> busy=0, rd=0, counter=0 at once; no wb_valid afterwards.
REQ-045 Stall held 70000 cycles -> counter saturates at 65535; perf_clr with stall=1 -> 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for a 5-stage pipeline with one multi-cycle execution unit.
// Produces the EX operand forwarding selects, the ID stall (load-use,
// RAW on a pending multi-cycle result, structural on the multi-cycle unit),
// tracks the multi-cycle unit's occupancy and counts stalled cycles.
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_id_valid,
  input  logic [REG_AW-1:0] in_id_rs1,
  input  logic [REG_AW-1:0] in_id_rs2,
  input  logic              in_id_mc_op,
  input  logic [REG_AW-1:0] in_idex_rs1,
  input  logic [REG_AW-1:0] in_idex_rs2,
  input  logic [REG_AW-1:0] in_idex_rd,
  input  logic              in_idex_memread,
  input  logic              in_idex_mc_start,
  input  logic              in_exmem_regwrite,
  input  logic [REG_AW-1:0] in_exmem_rd,
  input  logic              in_memwb_regwrite,
  input  logic [REG_AW-1:0] in_memwb_rd,
  input  logic              in_perf_clr,
  output logic [1:0]        out_forwarda_sel,
  output logic [1:0]        out_forwardb_sel,
  output logic              out_stall,
  output logic              out_mc_busy,
  output logic              out_mc_wb_valid,
  output logic [REG_AW-1:0] out_mc_rd,
  output logic              out_mc_start_ack,
  output logic [15:0]       out_stall_cycles,
  output logic              out_dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} mc_state_t;

  localparam logic [3:0]        CNT_LOAD = 4'(MC_LAT - 1);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  mc_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              mc_counting;
  logic              load_use_haz;
  logic              raw_mc_haz;
  logic              struct_haz;
  logic [15:0]       stall_cnt_q;

  // Operand source for one EX operand; the younger EX/MEM result wins.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (in_exmem_regwrite && (in_exmem_rd != REG_ZERO) && (in_exmem_rd == rs))
      return 2'b10;
    else if (in_memwb_regwrite && (in_memwb_rd != REG_ZERO) && (in_memwb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding selects, purely combinational from the pipeline registers.
  always_comb begin
    out_forwarda_sel = fwd_sel(in_idex_rs1);
    out_forwardb_sel = fwd_sel(in_idex_rs2);
  end

  // Multi-cycle state register; reset aborts any op in flight.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= REG_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state: load on an accepted start, count down, retire at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (out_mc_start_ack) begin
      state_d = ST_RUN;
      cnt_d   = CNT_LOAD;
      rd_d    = in_idex_rd;
    end else if (state_q == ST_RUN) begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else               state_d = ST_IDLE;
    end
  end

  // Outputs of the multi-cycle tracker.
  // Start handshake: in_idex_mc_start is a request held by EX; it is taken
  // only in the cycle out_mc_start_ack is high, which happens when the unit
  // is idle or is retiring its current op (cnt==0) that same cycle.
  // An unacknowledged request changes nothing.
  always_comb begin
    mc_counting      = (state_q == ST_RUN) && (cnt_q != 4'd0);
    out_mc_busy      = (state_q == ST_RUN);
    out_mc_wb_valid  = (state_q == ST_RUN) && (cnt_q == 4'd0);
    out_mc_start_ack = in_rst_n && in_idex_mc_start &&
                       ((state_q == ST_IDLE) || out_mc_wb_valid);
    out_mc_rd        = rd_q;
    out_dbg_state    = state_q;
  end

  // Stall sources; nothing stalls unless ID holds a live instruction.
  always_comb begin
    load_use_haz = in_id_valid && in_idex_memread && (in_idex_rd != REG_ZERO) &&
                   ((in_idex_rd == in_id_rs1) || (in_idex_rd == in_id_rs2));
    raw_mc_haz   = in_id_valid && mc_counting && (rd_q != REG_ZERO) &&
                   ((rd_q == in_id_rs1) || (rd_q == in_id_rs2));
    struct_haz   = in_id_valid && in_id_mc_op && (mc_counting || out_mc_start_ack);
    out_stall    = load_use_haz || raw_mc_haz || struct_haz;
  end

  // Saturating stall-cycle counter; clear takes priority.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)
      stall_cnt_q <= 16'd0;
    else if (in_perf_clr)
      stall_cnt_q <= 16'd0;
    else if (out_stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign out_stall_cycles = stall_cnt_q;

endmodule
